alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Upstream issue/writeback sequencer for the 8-bit combinational ALU (11 ops, opcodes 0-10, flags carry/zero/overflow/sign).
- Accepts one instruction per valid/ready handshake and reads operands from an internal 8x8 register file.
- Drives registered, glitch-free operands into the ALU, then captures result and flags one cycle later and writes the result back.
- Computes SGE/SGT locally, since the ALU returns no defined result for those opcodes.

Parameters:
WIDTH, 8, datapath/register width
NREG, 8, register-file entries
RAW, 3, register address width, equals log2(NREG)
SHW, 5, shift amount width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  high in IDLE and WB states
instr_opcode  in  4  ALU opcode
instr_rd  in  RAW  destination register
instr_rs1  in  RAW  operand-1 register
instr_rs2  in  RAW  operand-2 register
instr_use_imm  in  1  1: operand 2 = instr_imm
instr_imm  in  WIDTH  immediate operand
instr_shamt  in  SHW  shift amount
alu_opcode  out  4  registered ALU opcode
alu_input1  out  WIDTH  registered operand 1
alu_input2  out  WIDTH  registered operand 2
alu_shiftValue  out  SHW  registered shift amount
alu_result  in  WIDTH  ALU result
alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag  in  1 each  ALU flags
wb_valid  out  1  one-cycle writeback pulse
wb_rd  out  RAW  written register
wb_data  out  WIDTH  written value
flags_q  out  4  {carry, zero, overflow, sign} of last legal op
illegal_op  out  1  one-cycle pulse on opcode 11-15
dbg_addr  in  RAW  debug read address
dbg_data  out  WIDTH  combinational rf[dbg_addr]

Behaviour:
- Reset (async, active-high): state=IDLE; all rf entries, ALU operand regs, wb_*, flags_q and illegal_op cleared to 0.
- States: IDLE, EXEC, WB.
- Accept condition: instr_valid && instr_ready, on edge T.
  - Opcode 0-10: latch alu_* from rf[rs1], rs2/imm and shamt; go to EXEC.
  - Opcode 11-15: no latch; illegal_op=1 during T+1; go to IDLE; rf and flags_q unchanged.
- EXEC (cycle T+1): ALU inputs stable; instr_ready=0. At edge T+1: rf[rd] written, wb_* loaded, flags_q loaded; go to WB.
  - SGE/SGT: result = {7'b0, $signed(in1) >= / > $signed(in2)}; flags = {0, result==0, 0, 0}.
  - All other ops: result = alu_result; flags taken from ALU ports.
- WB (cycle T+2): wb_valid=1 and instr_ready=1.
  - New accept at this edge goes to EXEC; otherwise go to IDLE.
  - rf already holds the new value, so a back-to-back read-after-write needs no forwarding.
- Throughput: 1 instruction per 2 cycles sustained. Latency accept->wb_valid = 2 cycles.
- rd == rs1 == rs2 is legal; operands are sampled before the write.
- No hardwired-zero register.
- Reset asserted in EXEC: no write occurs, wb_valid stays 0.
- instr_valid dropped in WB: return to IDLE.
- dbg_data reflects writes from the edge onward.

Decomposition:
- Package alu_pkg:
  - opcode constants SGE=0, NAND=1, SLL=2, SGT=3, MIN=4, AND=5, NOR=6, SRA=7, XOR=8, ADD=9, MAX=10
  - OPC_LAST=10
  - state encoding
  - flag bit indices
- One sub-module, alu_regfile: NREG x WIDTH, two async read ports plus debug read port, one sync write port, async clear.

Test Plan:
- Reset then dbg sweep -> all rf = 0, flags_q = 0, instr_ready = 1.
- rf[1]=0x7F, rf[2]=0x01, ADD rd=3 -> alu_input1=0x7F, alu_input2=0x01 at T+1; wb_valid at T+2 with wb_data=alu_result; rf[3]=that value.
- SGT rs1=0x80 (-128), rs2=0x01 -> wb_data=0x00, flags_q=4'b0100. SGE with equal operands -> 0x01.
- Back-to-back: XOR r4=r1^r2 accepted in WB of prior op, then ADD reading r4 -> second op sees updated r4; wb_valid every 2 cycles.
- Opcode 13 -> illegal_op pulse at T+1; no wb_valid; rf and flags unchanged; instr_ready stays 1.
- Assert rst during EXEC of NOR rd=5 -> rf[5] unchanged (0), wb_valid never asserts, state returns to IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue/writeback sequencer.
package alu_pkg;

    localparam logic [3:0] OP_SGE  = 4'd0;
    localparam logic [3:0] OP_NAND = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SGT  = 4'd3;
    localparam logic [3:0] OP_MIN  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_ADD  = 4'd9;
    localparam logic [3:0] OP_MAX  = 4'd10;
    localparam logic [3:0] OPC_LAST = 4'd10;

    localparam int FLAG_CARRY = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_SIGN  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic opcode_legal(input logic [3:0] op);
        return op <= OPC_LAST;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two async read ports, one debug read port, one sync write port, async clear.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 8,
    parameter int RAW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [RAW-1:0]   waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [RAW-1:0]   raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic [RAW-1:0]   raddr2,
    output logic [WIDTH-1:0] rdata2,
    input  logic [RAW-1:0]   dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] mem_q [NREG];
    logic [WIDTH-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata1   = mem_q[raddr1];
    assign rdata2   = mem_q[raddr2];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer around an external combinational ALU: registers operands,
// captures result/flags one cycle later and writes back. SGE/SGT are resolved locally.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 8,
    parameter int RAW   = 3,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_opcode,
    input  logic [RAW-1:0]   instr_rd,
    input  logic [RAW-1:0]   instr_rs1,
    input  logic [RAW-1:0]   instr_rs2,
    input  logic             instr_use_imm,
    input  logic [WIDTH-1:0] instr_imm,
    input  logic [SHW-1:0]   instr_shamt,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [SHW-1:0]   alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryFlag,
    input  logic             alu_zeroFlag,
    input  logic             alu_overFlowFlag,
    input  logic             alu_signFlag,
    output logic             wb_valid,
    output logic [RAW-1:0]   wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic [3:0]       flags_q,
    output logic             illegal_op,
    input  logic [RAW-1:0]   dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    state_e           state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] in2_q, in2_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [RAW-1:0]   rd_q, rd_d;
    logic             wb_valid_q, wb_valid_d;
    logic [RAW-1:0]   wb_rd_q, wb_rd_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [3:0]       flags_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             rf_we;
    logic [WIDTH-1:0] rs1_data, rs2_data;
    logic [WIDTH-1:0] exec_result;
    logic [3:0]       exec_flags;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG),
        .RAW   (RAW)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (exec_result),
        .raddr1   (instr_rs1),
        .rdata1   (rs1_data),
        .raddr2   (instr_rs2),
        .rdata2   (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign instr_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
    assign accept      = instr_valid && instr_ready;

    // The ALU leaves SGE/SGT undefined, so compare the registered operands here.
    always_comb begin
        exec_result = alu_result;
        exec_flags  = '0;
        exec_flags[FLAG_CARRY] = alu_carryFlag;
        exec_flags[FLAG_ZERO]  = alu_zeroFlag;
        exec_flags[FLAG_OVF]   = alu_overFlowFlag;
        exec_flags[FLAG_SIGN]  = alu_signFlag;
        if (opcode_q == OP_SGE || opcode_q == OP_SGT) begin
            exec_result = '0;
            if (opcode_q == OP_SGE) begin
                exec_result[0] = $signed(in1_q) >= $signed(in2_q);
            end else begin
                exec_result[0] = $signed(in1_q) > $signed(in2_q);
            end
            exec_flags = '0;
            exec_flags[FLAG_ZERO] = (exec_result == '0);
        end
    end

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        shamt_d    = shamt_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        flags_d    = flags_q;
        illegal_d  = 1'b0;
        rf_we      = 1'b0;
        case (state_q)
            ST_IDLE, ST_WB: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (opcode_legal(instr_opcode)) begin
                        opcode_d = instr_opcode;
                        in1_d    = rs1_data;
                        in2_d    = instr_use_imm ? instr_imm : rs2_data;
                        shamt_d  = instr_shamt;
                        rd_d     = instr_rd;
                        state_d  = ST_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                rf_we      = 1'b1;
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = exec_result;
                flags_d    = exec_flags;
                state_d    = ST_WB;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            opcode_q   <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            shamt_q    <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            flags_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            shamt_q    <= shamt_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            flags_q    <= flags_d;
            illegal_q  <= illegal_d;
        end
    end

    assign alu_opcode     = opcode_q;
    assign alu_input1     = in1_q;
    assign alu_input2     = in2_q;
    assign alu_shiftValue = shamt_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU stand-in plus an architectural register-file model.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_opcode;
    logic [2:0] instr_rd, instr_rs1, instr_rs2;
    logic       instr_use_imm;
    logic [7:0] instr_imm;
    logic [4:0] instr_shamt;
    logic [3:0] alu_opcode;
    logic [7:0] alu_input1, alu_input2;
    logic [4:0] alu_shiftValue;
    logic [7:0] alu_result;
    logic       alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic [3:0] flags_q;
    logic       illegal_op;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int tests = 0;
    int fails = 0;
    logic [7:0] rf_m [8];
    logic [3:0] flags_m;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
        .instr_shamt(instr_shamt),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1),
        .alu_input2(alu_input2), .alu_shiftValue(alu_shiftValue),
        .alu_result(alu_result), .alu_carryFlag(alu_carryFlag),
        .alu_zeroFlag(alu_zeroFlag), .alu_overFlowFlag(alu_overFlowFlag),
        .alu_signFlag(alu_signFlag),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flags_q(flags_q), .illegal_op(illegal_op),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // External ALU stand-in: {carry, zero, overflow, sign, result}. SGE/SGT get junk on purpose.
    function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [4:0] sh);
        logic [8:0] sum;
        logic [7:0] r;
        logic c, v;
        sum = {1'b0, a} + {1'b0, b};
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd1:  r = ~(a & b);
            4'd2:  r = (sh > 7) ? 8'h00 : (a << sh);
            4'd4:  r = ($signed(a) < $signed(b)) ? a : b;
            4'd5:  r = a & b;
            4'd6:  r = ~(a | b);
            4'd7:  r = (sh > 7) ? {8{a[7]}} : 8'($signed(a) >>> sh);
            4'd8:  r = a ^ b;
            4'd9:  begin r = sum[7:0]; c = sum[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd10: r = ($signed(a) > $signed(b)) ? a : b;
            default: return {4'b1011, 8'hA5};
        endcase
        return {c, (r == 8'h00), v, r[7], r};
    endfunction

    always_comb begin
        {alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag, alu_result} =
            alu_fn(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one instruction now; leaves time at WB+2ns so the next call is back-to-back.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input bit ui, input logic [7:0] imm,
                         input logic [4:0] sh);
        logic [7:0] a, b, r;
        logic [3:0] f;
        a = rf_m[rs1];
        b = ui ? imm : rf_m[rs2];
        instr_valid = 1'b1; instr_opcode = op; instr_rd = rd; instr_rs1 = rs1;
        instr_rs2 = rs2; instr_use_imm = ui; instr_imm = imm; instr_shamt = sh;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        if (op > 4'd10) begin
            chk("illegal_pulse", illegal_op, 1);
            chk("illegal_no_wb", wb_valid, 0);
            chk("illegal_ready", instr_ready, 1);
            @(posedge clk); #1;
            chk("illegal_clear", illegal_op, 0);
            chk("illegal_no_wb2", wb_valid, 0);
            chk("illegal_flags", flags_q, flags_m);
            dbg_addr = rd; #1;
            chk("illegal_rf", dbg_data, rf_m[rd]);
            return;
        end
        chk("exec_opcode", alu_opcode, op);
        chk("exec_in1", alu_input1, a);
        chk("exec_in2", alu_input2, b);
        chk("exec_shamt", alu_shiftValue, sh);
        chk("exec_ready", instr_ready, 0);
        chk("exec_no_wb", wb_valid, 0);
        chk("exec_no_illegal", illegal_op, 0);
        if (op == 4'd0 || op == 4'd3) begin
            r = 8'h00;
            r[0] = (op == 4'd0) ? ($signed(a) >= $signed(b)) : ($signed(a) > $signed(b));
            f = {1'b0, (r == 8'h00), 2'b00};
        end else begin
            {f, r} = alu_fn(op, a, b, sh);
        end
        @(posedge clk); #1;
        chk("wb_valid", wb_valid, 1);
        chk("wb_rd", wb_rd, rd);
        chk("wb_data", wb_data, r);
        chk("wb_flags", flags_q, f);
        chk("wb_ready", instr_ready, 1);
        dbg_addr = rd; #1;
        chk("wb_rf", dbg_data, r);
        rf_m[rd] = r;
        flags_m = f;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_opcode = '0; instr_rd = '0; instr_rs1 = '0;
        instr_rs2 = '0; instr_use_imm = 1'b0; instr_imm = '0; instr_shamt = '0; dbg_addr = '0;
        for (int i = 0; i < 8; i++) rf_m[i] = 8'h00;
        flags_m = 4'h0;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_flags", flags_q, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_alu_in1", alu_input1, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            chk("rst_rf", dbg_data, 0);
        end
        @(posedge clk); #1;

        issue(4'd9, 3'd1, 3'd0, 3'd0, 1'b1, 8'h7F, 5'd0);
        issue(4'd9, 3'd2, 3'd0, 3'd0, 1'b1, 8'h01, 5'd0);
        @(posedge clk); #1;
        issue(4'd9, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 5'd0);
        chk("add_result", wb_data, 8'h80);

        issue(4'd9, 3'd6, 3'd0, 3'd0, 1'b1, 8'h80, 5'd0);
        issue(4'd3, 3'd7, 3'd6, 3'd2, 1'b0, 8'h00, 5'd0);
        chk("sgt_data", wb_data, 8'h00);
        chk("sgt_flags", flags_q, 4'b0100);
        issue(4'd0, 3'd7, 3'd1, 3'd1, 1'b0, 8'h00, 5'd0);
        chk("sge_equal", wb_data, 8'h01);

        issue(4'd8, 3'd4, 3'd1, 3'd2, 1'b0, 8'h00, 5'd0);
        issue(4'd9, 3'd0, 3'd4, 3'd1, 1'b0, 8'h00, 5'd0);
        chk("raw_b2b", wb_data, 8'hFD);

        issue(4'd13, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00, 5'd0);

        for (int n = 0; n < 40; n++) begin
            issue(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 8'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            chk("sweep_rf", dbg_data, rf_m[i]);
        end

        @(posedge clk); #1;
        instr_valid = 1'b1; instr_opcode = 4'd6; instr_rd = 3'd5; instr_rs1 = 3'd1;
        instr_rs2 = 3'd2; instr_use_imm = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("rst_exec_opcode", alu_opcode, 6);
        rst = 1'b1; #1;
        chk("rst_exec_no_wb", wb_valid, 0);
        chk("rst_exec_ready", instr_ready, 1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rf_m[i] = 8'h00;
        flags_m = 4'h0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_exec_no_wb_later", wb_valid, 0);
            chk("rst_exec_idle", instr_ready, 1);
        end
        dbg_addr = 3'd5; #1;
        chk("rst_exec_rf5", dbg_data, 0);
        chk("rst_exec_flags", flags_q, flags_m);
        @(posedge clk); #1;
        issue(4'd9, 3'd5, 3'd0, 3'd0, 1'b1, 8'h33, 5'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
